// File: rtl/cronometro_pkg.sv
// cronometro_pkg: shared state encoding and digit limits for the stopwatch run control.
package cronometro_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_PAUSE = 3'd2,
        ST_LAP   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [2:0] MAX_DEC = 3'd5;
    localparam logic [3:0] MAX_DIG = 4'd9;

    function automatic logic is_max(logic [2:0] dec, logic [3:0] uni, logic [3:0] dcm, logic [3:0] cen);
        return dec == MAX_DEC && uni == MAX_DIG && dcm == MAX_DIG && cen == MAX_DIG;
    endfunction

endpackage

// File: rtl/cronometro_control_if.sv
// cronometro_control_if: buttons, digit chain values and control outputs of the stopwatch run control.
interface cronometro_control_if;
    logic       btn_start_stop;
    logic       btn_reset;
    logic       btn_lap;
    logic [2:0] decenas;
    logic [3:0] unidades;
    logic [3:0] decimas;
    logic [3:0] centesimas;
    logic       stay;
    logic       clr;
    logic       hold;
    logic       running;
    logic [2:0] state;

    modport master (
        output btn_start_stop, btn_reset, btn_lap, decenas, unidades, decimas, centesimas,
        input  stay, clr, hold, running, state
    );

    modport slave (
        input  btn_start_stop, btn_reset, btn_lap, decenas, unidades, decimas, centesimas,
        output stay, clr, hold, running, state
    );
endinterface

// File: rtl/cronometro_control_btn_sync_edge.sv
// btn_sync_edge: two-flop synchronizer for an asynchronous button level plus a one-cycle rising-edge pulse.
module btn_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic ev
);
    logic [2:0] sh;

    always_ff @(posedge clk or negedge rst)
        if (!rst) sh <= '0;
        else      sh <= {sh[1:0], btn};

    // sh[2] is the edge register, so the pulse comes only from already-synchronized bits
    assign ev = sh[1] & ~sh[2];
endmodule

// File: rtl/cronometro_control.sv
// cronometro_control: run/pause/lap FSM, centisecond prescaler and 59.99 s detect for the stopwatch digit chain.
module cronometro_control
    import cronometro_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 100,
    parameter bit WRAP    = 1'b1
) (
    input logic clk,
    input logic rst,
    cronometro_control_if.slave bus
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);
    localparam logic [PW-1:0] TOP = PW'(DIV - 1);

    state_t st;
    logic [PW-1:0] pre;
    logic stay_r, clr_r, hold_r, running_r;
    logic ev_ss, ev_rst, ev_lap;
    logic act, tick, done;

    btn_sync_edge u_ss  (.clk(clk), .rst(rst), .btn(bus.btn_start_stop), .ev(ev_ss));
    btn_sync_edge u_rst (.clk(clk), .rst(rst), .btn(bus.btn_reset),      .ev(ev_rst));
    btn_sync_edge u_lap (.clk(clk), .rst(rst), .btn(bus.btn_lap),        .ev(ev_lap));

    assign act  = st == ST_RUN || st == ST_LAP;
    assign tick = act && pre == TOP;
    // without wrap, the tick that would roll 59.99 over is swallowed and the watch parks in DONE
    assign done = tick && !WRAP && is_max(bus.decenas, bus.unidades, bus.decimas, bus.centesimas);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st        <= ST_IDLE;
            pre       <= '0;
            stay_r    <= 1'b0;
            clr_r     <= 1'b0;
            hold_r    <= 1'b0;
            running_r <= 1'b0;
        end else if (ev_rst) begin
            st        <= ST_IDLE;
            pre       <= '0;
            stay_r    <= 1'b0;
            clr_r     <= 1'b1;
            hold_r    <= 1'b0;
            running_r <= 1'b0;
        end else begin
            clr_r  <= 1'b0;
            stay_r <= tick && !done;
            if (act) pre <= tick ? '0 : pre + 1'b1;
            case (st)
                ST_IDLE:
                    if (ev_ss) begin
                        st        <= ST_RUN;
                        pre       <= '0;
                        running_r <= 1'b1;
                    end
                ST_RUN, ST_LAP:
                    if (done) begin
                        st        <= ST_DONE;
                        running_r <= 1'b0;
                    end else if (ev_ss) begin
                        st        <= ST_PAUSE;
                        running_r <= 1'b0;
                    end else if (ev_lap) begin
                        st     <= st == ST_RUN ? ST_LAP : ST_RUN;
                        hold_r <= st == ST_RUN;
                    end
                ST_PAUSE:
                    if (ev_ss) begin
                        st        <= hold_r ? ST_LAP : ST_RUN;
                        running_r <= 1'b1;
                    end
                ST_DONE: ;
                default: begin
                    st        <= ST_IDLE;
                    running_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.stay    = stay_r;
    assign bus.clr     = clr_r;
    assign bus.hold    = hold_r;
    assign bus.running = running_r;
    assign bus.state   = st;
endmodule
